// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// SPI flash device stand-in: decodes fast read (0x0B) and dual-output fast read (0x3B),
// streams bytes fetched one ahead through a byte-wide memory request port.
module spi_flash_responder (
  input  logic        C25M,
  input  logic        nRES,
  input  logic        nFCS,
  input  logic        FCK,
  input  logic        MOSIin,
  output logic        MOSIout,
  output logic        MOSIOE,
  output logic        MISOout,
  output logic        MISOOE,
  output logic [23:0] MemAddr,
  output logic        MemReq,
  input  logic        MemAck,
  input  logic [7:0]  MemD,
  output logic        CmdErr,
  output logic        Underrun
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  logic        fcs_s1_q, fcs_s2_q, fcs_d1_q;
  logic        fck_s1_q, fck_s2_q, fck_d1_q;
  logic        mosi_s1_q, mosi_s2_q;
  logic [2:0]  state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [22:0] sh_q, sh_d;
  logic        dual_q, dual_d;
  logic [7:0]  sr_q, sr_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [7:0]  pf_q, pf_d;
  logic        pf_valid_q, pf_valid_d;
  logic [23:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        cmderr_q, cmderr_d;
  logic        underrun_q, underrun_d;
  logic        oe_q, oe_d, oe_dual_q, oe_dual_d;
  logic        mosi_q, mosi_d, miso_q, miso_d;
  logic        rise, fall, cs_fall, load;
  logic [7:0]  opcode;
  logic [23:0] addr_in;

  assign rise    = fck_s2_q & ~fck_d1_q;
  assign fall    = ~fck_s2_q & fck_d1_q;
  assign cs_fall = ~fcs_s2_q & fcs_d1_q;
  assign opcode  = {sh_q[6:0], mosi_s2_q};
  assign addr_in = {sh_q, mosi_s2_q};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sh_d       = sh_q;
    dual_d     = dual_q;
    sr_d       = sr_q;
    dcnt_d     = dcnt_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    addr_d     = addr_q;
    req_d      = req_q;
    cmderr_d   = 1'b0;
    underrun_d = underrun_q;
    oe_d       = oe_q;
    oe_dual_d  = oe_dual_q;
    mosi_d     = mosi_q;
    miso_d     = miso_q;
    load       = 1'b0;
    if (req_q && MemAck) begin
      pf_d       = MemD;
      pf_valid_d = 1'b1;
      req_d      = 1'b0;
    end
    // Deselect wins over everything, including an acknowledge landing this cycle.
    if (fcs_s2_q) begin
      state_d    = S_IDLE;
      req_d      = 1'b0;
      pf_valid_d = 1'b0;
      oe_d       = 1'b0;
      oe_dual_d  = 1'b0;
    end else if (cs_fall) begin
      state_d    = S_CMD;
      bitcnt_d   = '0;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        S_CMD: if (rise) begin
          sh_d     = {sh_q[21:0], mosi_s2_q};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd7) begin
            bitcnt_d = '0;
            if (opcode == 8'h3B) begin
              state_d = S_ADDR;
              dual_d  = 1'b1;
            end else if (opcode == 8'h0B) begin
              state_d = S_ADDR;
              dual_d  = 1'b0;
            end else begin
              cmderr_d = 1'b1;
              state_d  = S_IGNORE;
            end
          end
        end
        S_ADDR: if (rise) begin
          sh_d     = {sh_q[21:0], mosi_s2_q};
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            addr_d   = addr_in;
            req_d    = 1'b1;
            state_d  = S_DUMMY;
          end
        end
        S_DUMMY: if (rise) begin
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_q == 5'd7) begin
            bitcnt_d = '0;
            load     = 1'b1;
            dcnt_d   = '0;
            state_d  = S_DATA;
          end
        end
        S_DATA: if (fall) begin
          miso_d    = sr_q[7];
          oe_d      = 1'b1;
          oe_dual_d = dual_q;
          dcnt_d    = dcnt_q + 4'd1;
          if (dual_q) begin
            mosi_d = sr_q[6];
            sr_d   = {sr_q[5:0], 2'b00};
          end else begin
            sr_d   = {sr_q[6:0], 1'b0};
          end
        end else if (rise && dcnt_q == (dual_q ? 4'd4 : 4'd8)) begin
          load   = 1'b1;
          dcnt_d = '0;
        end
        default: ;
      endcase
    end
    // Same-cycle acknowledge is forwarded straight into the shift register.
    if (load) begin
      if (pf_valid_q) begin
        sr_d = pf_q;
      end else if (req_q && MemAck) begin
        sr_d = MemD;
      end else begin
        sr_d       = 8'hFF;
        underrun_d = 1'b1;
      end
      pf_valid_d = 1'b0;
      addr_d     = addr_q + 24'd1;
      req_d      = 1'b1;
    end
  end

  always_ff @(posedge C25M or negedge nRES) begin
    if (!nRES) begin
      fcs_s1_q   <= 1'b0;
      fcs_s2_q   <= 1'b0;
      fcs_d1_q   <= 1'b0;
      fck_s1_q   <= 1'b0;
      fck_s2_q   <= 1'b0;
      fck_d1_q   <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      sh_q       <= '0;
      dual_q     <= 1'b0;
      sr_q       <= '0;
      dcnt_q     <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      cmderr_q   <= 1'b0;
      underrun_q <= 1'b0;
      oe_q       <= 1'b0;
      oe_dual_q  <= 1'b0;
      mosi_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      fcs_s1_q   <= nFCS;
      fcs_s2_q   <= fcs_s1_q;
      fcs_d1_q   <= fcs_s2_q;
      fck_s1_q   <= FCK;
      fck_s2_q   <= fck_s1_q;
      fck_d1_q   <= fck_s2_q;
      mosi_s1_q  <= MOSIin;
      mosi_s2_q  <= mosi_s1_q;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sh_q       <= sh_d;
      dual_q     <= dual_d;
      sr_q       <= sr_d;
      dcnt_q     <= dcnt_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      cmderr_q   <= cmderr_d;
      underrun_q <= underrun_d;
      oe_q       <= oe_d;
      oe_dual_q  <= oe_dual_d;
      mosi_q     <= mosi_d;
      miso_q     <= miso_d;
    end
  end

  assign MOSIout  = mosi_q;
  assign MISOout  = miso_q;
  assign MOSIOE   = oe_dual_q & ~nFCS;
  assign MISOOE   = oe_q & ~nFCS;
  assign MemAddr  = addr_q;
  assign MemReq   = req_q;
  assign CmdErr   = cmderr_q;
  assign Underrun = underrun_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
// Directed bench for spi_flash_responder: the bench is SPI master and byte memory
// (contents = low address byte) and checks the serial stream against that content model.
module tb_spi_flash_responder;
  logic        C25M = 1'b0;
  logic        nRES = 1'b1;
  logic        nFCS = 1'b1;
  logic        FCK = 1'b0;
  logic        MOSIin = 1'b0;
  logic        MemAck = 1'b0;
  logic [7:0]  MemD = 8'h00;
  logic        MOSIout, MOSIOE, MISOout, MISOOE, MemReq, CmdErr, Underrun;
  logic [23:0] MemAddr;

  int errors = 0;
  int checks = 0;
  int mem_lat = 3;
  int mem_first_lat = 0;
  int mem_cnt = 0;
  logic [23:0] ack_addr[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  logic [7:0]  v;
  bit in_data = 1'b0;
  bit cur_dual = 1'b0;
  int rise_idx = 0;
  int cmderr_cycles = 0;
  bit memreq_seen = 1'b0;
  bit oe_seen = 1'b0;
  bit mosioe_seen = 1'b0;
  logic [7:0] lit_dual [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
  logic [7:0] lit_wrap [3] = '{8'hFE, 8'hFF, 8'h00};
  logic [7:0] lit_under [3] = '{8'hFF, 8'h41, 8'h42};

  spi_flash_responder dut (
    .C25M(C25M), .nRES(nRES), .nFCS(nFCS), .FCK(FCK), .MOSIin(MOSIin),
    .MOSIout(MOSIout), .MOSIOE(MOSIOE), .MISOout(MISOout), .MISOOE(MISOOE),
    .MemAddr(MemAddr), .MemReq(MemReq), .MemAck(MemAck), .MemD(MemD),
    .CmdErr(CmdErr), .Underrun(Underrun)
  );

  always #20 C25M = ~C25M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] start, input int i, input bit under_first);
    logic [23:0] a;
    a = start + 24'(i);
    if (under_first && i == 0) return 8'hFF;
    return a[7:0];
  endfunction

  function automatic logic [23:0] model_addr(input logic [23:0] start, input int i);
    return start + 24'(i);
  endfunction

  // Memory: acknowledges after a latency, data is the low byte of MemAddr at ack time.
  initial forever begin
    @(negedge C25M);
    if (MemAck) MemAck = 1'b0;
    else if (MemReq) begin
      mem_cnt++;
      if (mem_cnt >= ((mem_first_lat != 0) ? mem_first_lat : mem_lat)) begin
        MemAck = 1'b1;
        MemD = MemAddr[7:0];
        ack_addr.push_back(MemAddr);
        mem_cnt = 0;
        mem_first_lat = 0;
      end
    end else mem_cnt = 0;
  end

  // Per-cycle compare against the expected byte stream while the master holds FCK high.
  initial forever begin
    int k;
    int j;
    logic [7:0] b;
    @(posedge C25M);
    #1;
    if (CmdErr) cmderr_cycles++;
    if (MemReq) memreq_seen = 1'b1;
    if (MISOOE || MOSIOE) oe_seen = 1'b1;
    if (MOSIOE) mosioe_seen = 1'b1;
    if (nFCS && nRES) check("oe_while_deselected", 32'({MOSIOE, MISOOE}), 32'h0);
    if (in_data && FCK) begin
      k = rise_idx - 1;
      if (cur_dual) begin
        b = exp_q[k / 4];
        j = k % 4;
        check("dual_miso_bit", 32'(MISOout), 32'(b[7 - 2*j]));
        check("dual_mosi_bit", 32'(MOSIout), 32'(b[6 - 2*j]));
        check("dual_oes", 32'({MOSIOE, MISOOE}), 32'h3);
      end else begin
        b = exp_q[k / 8];
        j = k % 8;
        check("single_miso_bit", 32'(MISOout), 32'(b[7 - j]));
        check("single_oes", 32'({MOSIOE, MISOOE}), 32'h1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge C25M);
  endtask

  task automatic spi_bit(input logic b);
    MOSIin = b;
    tick(4);
    FCK = 1'b1;
    tick(4);
    FCK = 1'b0;
  endtask

  task automatic spi_bits(input logic [23:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(val[i]);
  endtask

  task automatic data_clock(output logic mi, output logic mo);
    tick(4);
    mi = MISOout;
    mo = MOSIout;
    FCK = 1'b1;
    rise_idx++;
    tick(4);
    FCK = 1'b0;
  endtask

  task automatic start_read(input logic [7:0] op, input logic [23:0] addr, input int nbytes, input bit under_first);
    cur_dual = (op == 8'h3B);
    exp_q.delete();
    for (int i = 0; i < nbytes; i++) exp_q.push_back(model_byte(addr, i, under_first));
    ack_addr.delete();
    got.delete();
    nFCS = 1'b0;
    tick(4);
    spi_bits({16'h0000, op}, 8);
    spi_bits(addr, 24);
    spi_bits(24'h0, 8);
    rise_idx = 0;
    in_data = 1'b1;
  endtask

  task automatic read_byte(output logic [7:0] val);
    logic mi, mo;
    val = '0;
    if (cur_dual) begin
      for (int j = 0; j < 4; j++) begin data_clock(mi, mo); val = {val[5:0], mi, mo}; end
    end else begin
      for (int j = 0; j < 8; j++) begin data_clock(mi, mo); val = {val[6:0], mi}; end
    end
  endtask

  task automatic deselect();
    in_data = 1'b0;
    nFCS = 1'b1;
    tick(6);
  endtask

  task automatic check_acks(input logic [23:0] start, input int n);
    check("ack_count", 32'(ack_addr.size() >= n), 32'h1);
    for (int i = 0; i < n && i < ack_addr.size(); i++)
      check("mem_addr_seq", 32'(ack_addr[i]), 32'(model_addr(start, i)));
  endtask

  initial begin
    #10 nRES = 1'b0;
    tick(3);
    check("reset_memaddr", 32'(MemAddr), 32'h0);
    check("reset_outputs", 32'({MOSIout, MOSIOE, MISOout, MISOOE, MemReq, CmdErr, Underrun}), 32'h0);
    nRES = 1'b1;
    tick(4);

    // Dual read from 0x001000
    start_read(8'h3B, 24'h001000, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin read_byte(v); got.push_back(v); end
    deselect();
    for (int i = 0; i < 4; i++) check("dual_byte", 32'(got[i]), 32'(lit_dual[i]));
    check_acks(24'h001000, 4);
    check("dual_first_addr", 32'(ack_addr[0]), 32'h001000);

    // Single read wrapping the 24-bit address
    mosioe_seen = 1'b0;
    start_read(8'h0B, 24'hFFFFFE, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin read_byte(v); got.push_back(v); end
    deselect();
    for (int i = 0; i < 3; i++) check("single_byte", 32'(got[i]), 32'(lit_wrap[i]));
    check_acks(24'hFFFFFE, 3);
    check("wrap_addr", 32'(ack_addr[2]), 32'h000000);
    check("single_mosioe_never", 32'(mosioe_seen), 32'h0);

    // Unsupported opcode followed by 32 clocks containing a valid opcode pattern
    cmderr_cycles = 0;
    memreq_seen = 1'b0;
    oe_seen = 1'b0;
    nFCS = 1'b0;
    tick(4);
    spi_bits(24'h00009F, 8);
    spi_bits(24'h003B3B, 16);
    spi_bits(24'h00A5C3, 16);
    deselect();
    check("cmderr_cycles", 32'(cmderr_cycles), 32'h1);
    check("badop_memreq", 32'(memreq_seen), 32'h0);
    check("badop_oes", 32'(oe_seen), 32'h0);

    // Deselect after two dual bit pairs while a prefetch is still outstanding
    mem_lat = 30;
    start_read(8'h3B, 24'h002040, 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      logic mi, mo;
      data_clock(mi, mo);
    end
    in_data = 1'b0;
    check("desel_req_pending", 32'(MemReq), 32'h1);
    check("desel_oes_before", 32'({MOSIOE, MISOOE}), 32'h3);
    nFCS = 1'b1;
    #1;
    check("desel_oes_same_cycle", 32'({MOSIOE, MISOOE}), 32'h0);
    repeat (3) @(posedge C25M);
    #1;
    check("desel_req_drop", 32'(MemReq), 32'h0);
    tick(40);
    mem_lat = 3;
    start_read(8'h3B, 24'h002080, 2, 1'b0);
    for (int i = 0; i < 2; i++) begin read_byte(v); got.push_back(v); end
    deselect();
    check("after_desel_byte0", 32'(got[0]), 32'h80);
    check("after_desel_byte1", 32'(got[1]), 32'h81);

    // Underrun: first acknowledge arrives after the dummy phase has ended
    mem_first_lat = 80;
    start_read(8'h3B, 24'h000040, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin read_byte(v); got.push_back(v); end
    check("underrun_set", 32'(Underrun), 32'h1);
    deselect();
    for (int i = 0; i < 3; i++) check("underrun_byte", 32'(got[i]), 32'(lit_under[i]));
    check("underrun_late_addr", 32'(ack_addr[0]), 32'h000041);
    check("underrun_sticky", 32'(Underrun), 32'h1);
    nFCS = 1'b0;
    tick(4);
    check("underrun_cleared_on_select", 32'(Underrun), 32'h0);
    deselect();

    // Reset after 10 address bits
    nFCS = 1'b0;
    tick(4);
    spi_bits(24'h00003B, 8);
    spi_bits(24'h000155, 10);
    check("pre_reset_memaddr_nonzero", 32'(MemAddr != 24'h0), 32'h1);
    nRES = 1'b0;
    #1;
    check("midreset_memaddr", 32'(MemAddr), 32'h0);
    check("midreset_outputs", 32'({MOSIout, MOSIOE, MISOout, MISOOE, MemReq, CmdErr, Underrun}), 32'h0);
    nFCS = 1'b1;
    tick(4);
    nRES = 1'b1;
    tick(4);
    start_read(8'h3B, 24'h0030A5, 2, 1'b0);
    for (int i = 0; i < 2; i++) begin read_byte(v); got.push_back(v); end
    deselect();
    check("post_reset_byte0", 32'(got[0]), 32'hA5);
    check("post_reset_byte1", 32'(got[1]), 32'hA6);
    check_acks(24'h0030A5, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
